// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle restoring divider, one quotient bit per clock, signed/unsigned.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration loop when |dividend| < |divisor|.
module seq_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [CNT_W-1:0] ITER = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             zero_q, zero_d;
    logic             skip_q, skip_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0] dvd_abs, dvs_abs, diff;
    logic [WIDTH:0]   part;
    logic             accept, early;

    always_comb begin
        dvd_abs = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
        dvs_abs = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
        // Partial remainder before the shift is below the divisor, so the
        // low WIDTH bits of the difference are exact whenever part >= divisor.
        part    = {rem_q, quo_q[WIDTH-1]};
        diff    = part[WIDTH-1:0] - dvs_q;
        accept  = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
`ifdef DIV_EARLY_OUT_EN
        early   = (dvs_q != '0) && (dvd_abs < dvs_abs);
`else
        early   = 1'b0;
`endif

        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        zero_d  = zero_q;
        skip_d  = skip_q;
        div0_d  = div0_q;

        if (accept) begin
            dvd_d = dividend;
            dvs_d = divisor;
            sgn_d = is_signed;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_LOAD;
            end
            S_LOAD: begin
                dvs_d   = dvs_abs;
                quo_d   = dvd_abs;
                rem_d   = '0;
                q_neg_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                r_neg_d = sgn_q & dvd_q[WIDTH-1];
                zero_d  = (dvs_q == '0);
                skip_d  = early;
                // Special-result paths enter CALC already exhausted, giving them
                // the same fixed short latency without a dedicated state.
                cnt_d   = ((dvs_q == '0) || early) ? ITER : '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                if (cnt_q == ITER) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (part >= {1'b0, dvs_q}) begin
                        rem_d = diff;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = part[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (zero_q) begin
                    q_out_d = '1;
                    r_out_d = dvd_q;
                    div0_d  = 1'b1;
                end else if (skip_q) begin
                    q_out_d = '0;
                    r_out_d = dvd_q;
                    div0_d  = 1'b0;
                end else begin
                    q_out_d = q_neg_q ? -quo_q : quo_q;
                    r_out_d = r_neg_q ? -rem_q : rem_q;
                    div0_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = accept ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            skip_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            zero_q  <= zero_d;
            skip_q  <= skip_d;
            div0_q  <= div0_d;
        end
    end

    assign busy      = (state_q == S_LOAD) || (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign quotient  = q_out_q;
    assign remainder = r_out_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: arithmetic reference model, randomized operands.
module tb_seq_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div0;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;

    always #5 clk = ~clk;

    seq_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0)
    );

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
`ifdef DIV_EARLY_OUT_EN
        logic [W-1:0] ma, mb;
        ma = (s && a[W-1]) ? -a : a;
        mb = (s && b[W-1]) ? -b : b;
`endif
        z   = (b == '0);
        lat = W + 3;
        if (z) begin
            q   = '1;
            r   = a;
            lat = 3;
        end else if (s && a == MIN && b == '1) begin
            q = MIN;
            r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
`ifdef DIV_EARLY_OUT_EN
        if (!z && ma < mb) lat = 3;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
        logic [W-1:0] eq, er;
        logic         ez;
        int           elat, n;
        model(a, b, s, eq, er, ez, elat);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = ~s;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_start: got %b expected 1", tag, busy);
        end
        n = 0;
        while (n < 100) begin
            if (done === 1'b1) break;
            n_cmp++;
            if (quotient !== last_q || remainder !== last_r || div0 !== last_z) begin
                n_err++;
                $display("FAIL %s outputs_stable: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         tag, quotient, remainder, div0, last_q, last_r, last_z);
            end
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s timeout: no done after %0d cycles, expected %0d", tag, n, elat);
            return;
        end
        n_cmp++;
        if (n != elat) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", tag, n, elat);
        end
        n_cmp++;
        if (quotient !== eq) begin
            n_err++;
            $display("FAIL %s quotient: got %h expected %h (a=%h b=%h s=%b)", tag, quotient, eq, a, b, s);
        end
        n_cmp++;
        if (remainder !== er) begin
            n_err++;
            $display("FAIL %s remainder: got %h expected %h (a=%h b=%h s=%b)", tag, remainder, er, a, b, s);
        end
        n_cmp++;
        if (div0 !== ez || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s div0_busy: got div0=%b busy=%b expected div0=%b busy=0", tag, div0, busy, ez);
        end
        last_q = eq;
        last_r = er;
        last_z = ez;
    endtask

    task automatic check_idle_outputs(input string tag);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div0 !== 1'b0) begin
            n_err++;
            $display("FAIL %s reset_values: got busy=%b done=%b q=%h r=%h z=%b expected all 0",
                     tag, busy, done, quotient, remainder, div0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");
        last_q = '0; last_r = '0; last_z = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] eq, er;
        logic         ez;
        int           elat;
        logic [W-1:0] ta [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234_5678, 32'h1234_5678, MIN, MIN, 32'd3};
        logic [W-1:0] tb [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd10};
        logic         ts [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], ts[i], $sformatf("directed%0d", i));
            model(ta[i], tb[i], ts[i], eq, er, ez, elat);
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || quotient !== eq || remainder !== er || div0 !== ez) begin
                n_err++;
                $display("FAIL directed%0d hold: got done=%b q=%h r=%h z=%b expected done=0 q=%h r=%h z=%b",
                         i, done, quotient, remainder, div0, eq, er, ez);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 100 && done !== 1'b1) begin
            if (n == 9) begin
                start = 1'b1; dividend = 32'd5; divisor = 32'd5; is_signed = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        n_cmp++;
        if (done !== 1'b1 || n != W + 3 || quotient !== 32'd333 || remainder !== 32'd1) begin
            n_err++;
            $display("FAIL busy_ignore: got done=%b lat=%0d q=%h r=%h expected done=1 lat=%0d q=%h r=%h",
                     done, n, quotient, remainder, W + 3, 32'd333, 32'd1);
        end
        last_q = 32'd333; last_r = 32'd1; last_z = 1'b0;
    endtask

    task automatic test_flush();
        logic seen;
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) begin
                start = 1'b1; dividend = 32'd5; divisor = 32'd5;
            end
            if (c == 20) flush = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            flush = 1'b0;
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_done: got done pulse=%b expected 0", seen);
        end
        n_cmp++;
        if (quotient !== last_q || remainder !== last_r || div0 !== last_z) begin
            n_err++;
            $display("FAIL flush_outputs_kept: got q=%h r=%h expected q=%h r=%h", quotient, remainder, last_q, last_r);
        end
        run_op(32'd9, 32'd4, 1'b0, "after_flush");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_op($urandom, $urandom_range(1, 40), i[0], $sformatf("b2b%0d", i));
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         s;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'(($urandom));
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: begin a = $urandom_range(0, 200); b = $urandom_range(201, 100000); end
                3: begin a = MIN; b = '1; end
                4: b = -$urandom_range(1, 9);
                default: ;
            endcase
            run_op(a, b, s, $sformatf("rand%0d", i));
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        run_op(32'd100, 32'd7, 1'b0, "pre_reset");
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        last_q = '0; last_r = '0; last_z = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("async_reset_release");
        run_op(32'd9, 32'd4, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        run_op(32'd3, 32'd10, 1'b0, "small_over_large");
        run_op(32'hFFFF_FFFD, 32'd10, 1'b1, "neg_small_over_large");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
